// File: rtl/keypad_scan_if.sv
// Keypad scanner bus: column drive and row sense toward the matrix, key events toward display logic.
// master = scanner, slave = keypad/consumer side.
interface keypad_scan_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  modport master (input row_n, output col_n, key_code, key_valid, key_held, multi_key);
  modport slave  (output row_n, input col_n, key_code, key_valid, key_held, multi_key);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotating active-low column drive, whole-scan debounce,
// key encoding with a press strobe, a held level and a multi-key flag.
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic           clk,
  input logic           rst,
  keypad_scan_if.master bus
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  state_t           state;
  logic [1:0][3:0]  sync_pipe;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       acc_cnt;
  logic [3:0]       acc_code;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       code_q;
  logic             valid_q, held_q, multi_q;

  logic       tick, scan_end;
  logic [3:0] pressed;
  logic [2:0] hit_cnt;
  logic [1:0] low_row;
  logic [3:0] sum;
  logic [1:0] scan_cnt;
  logic [3:0] samp_code, new_code;
  logic       res_none, res_single, res_multi;

  assign tick     = (div_cnt == DIV_LAST);
  assign scan_end = tick && (col_idx == 2'd3);
  assign pressed  = ~sync_pipe[1];

  // Hits in the current column; the loop runs high-to-low so the lowest pressed row wins.
  always_comb begin
    hit_cnt = 3'd0;
    low_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      hit_cnt = hit_cnt + {2'b00, pressed[r]};
      if (pressed[r]) low_row = 2'(r);
    end
  end

  // Merge this column's sample into the running scan; count saturates at 2 (= MULTI).
  assign sum        = {2'b00, acc_cnt} + {1'b0, hit_cnt};
  assign scan_cnt   = (sum >= 4'd2) ? 2'd2 : sum[1:0];
  assign samp_code  = {low_row, col_idx};
  assign new_code   = (hit_cnt != 3'd0 && (acc_cnt == 2'd0 || samp_code < acc_code)) ? samp_code : acc_code;
  assign res_none   = (scan_cnt == 2'd0);
  assign res_single = (scan_cnt == 2'd1);
  assign res_multi  = (scan_cnt == 2'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sync_pipe <= '1;  // idle rows read as pulled-up: no key
      div_cnt   <= '0;
      col_idx   <= 2'd0;
      acc_cnt   <= 2'd0;
      acc_code  <= 4'd0;
      cand      <= 4'd0;
      cnt       <= '0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      sync_pipe[0] <= bus.row_n;
      sync_pipe[1] <= sync_pipe[0];
      valid_q      <= 1'b0;
      div_cnt      <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        col_idx <= col_idx + 2'd1;
        if (!scan_end) begin
          acc_cnt  <= scan_cnt;
          acc_code <= new_code;
        end else begin
          acc_cnt  <= 2'd0;
          acc_code <= 4'd0;
          multi_q  <= res_multi;
          case (state)
            IDLE: if (res_single) begin
              cand <= new_code;
              if (DEBOUNCE_SCANS == 1) begin
                state   <= HELD;
                code_q  <= new_code;
                valid_q <= 1'b1;
                held_q  <= 1'b1;
                cnt     <= '0;
              end else begin
                state <= DEBOUNCE;
                cnt   <= CNT_W'(1);
              end
            end
            DEBOUNCE: begin
              if (res_single && new_code == cand) begin
                if (cnt == DEB_LAST) begin
                  state   <= HELD;
                  code_q  <= cand;
                  valid_q <= 1'b1;
                  held_q  <= 1'b1;
                  cnt     <= '0;
                end else begin
                  cnt <= cnt + CNT_W'(1);
                end
              end else begin
                state <= IDLE;
                cnt   <= '0;
              end
            end
            HELD: if (res_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                state  <= IDLE;
                held_q <= 1'b0;
                cnt    <= '0;
              end else begin
                state <= RELEASE;
                cnt   <= CNT_W'(1);
              end
            end
            RELEASE: begin
              if (res_none) begin
                if (cnt == DEB_LAST) begin
                  state  <= IDLE;
                  held_q <= 1'b0;
                  cnt    <= '0;
                end else begin
                  cnt <= cnt + CNT_W'(1);
                end
              end else begin
                // Bounce during release: resume the hold without a new strobe.
                state <= HELD;
                cnt   <= '0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.col_n     = ~(4'b0001 << col_idx);
  assign bus.key_code  = code_q;
  assign bus.key_valid = valid_q;
  assign bus.key_held  = held_q;
  assign bus.multi_key = multi_q;
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Reads a 4x4 matrix keypad, the input-side counterpart of the LED / 7-segment display drivers.
- Drives the columns with a rotating active-low one-hot pattern and samples the active-low rows.
- Debounces over whole scans, encodes the pressed key, and gives the display/pattern logic a one-cycle press strobe plus a held level.

Parameters:
SCAN_DIV, 50000, clk cycles per column step; 1 kHz column rate at 50 MHz; minimum 2.
DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; minimum 1.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
col_n  output  4  column drive, active-low one-hot
key_code  output  4  code of accepted key = 4*row + col
key_valid  output  1  one-cycle strobe when a press is accepted
key_held  output  1  high from acceptance until release is accepted
multi_key  output  1  high when the last completed scan saw two or more keys

Behaviour:
- Reset values (rst low, any time):
  - col_n=4'b1110, key_code=0, key_valid=0, key_held=0, multi_key=0
  - FSM=IDLE; all counters and the synchronizer cleared
  - Reset mid-operation aborts any pending acceptance; no key_valid is produced.
- Synchronizer: row_n passes through 2 flops before any use.
- Tick generator:
  - Counter 0..SCAN_DIV-1, wraps to 0.
  - tick is asserted for 1 cycle when counter==SCAN_DIV-1.
- Column scan:
  - col_idx (2 bits) selects the column; col_n = ~(1<<col_idx).
  - On tick, the synchronized rows are sampled for the current col_idx, then col_idx increments (3 wraps to 0).
  - Each column therefore settles for a full SCAN_DIV cycles before sampling.
- Scan accumulation:
  - A scan is 4 samples, col 0..3.
  - Per scan, count the pressed intersections, saturating at 2.
  - Capture the code of the lowest-numbered pressed key.
  - At the tick sampling col 3, classify the scan as NONE, SINGLE(code) or MULTI, then clear the accumulators for the next scan.
  - multi_key is updated at every scan end: 1 if MULTI, else 0.
- Debounce FSM (evaluated only at scan end):
  - IDLE:
    - SINGLE(c) -> DEBOUNCE, cand=c, cnt=1.
    - NONE or MULTI -> stay.
    - When DEBOUNCE_SCANS=1, SINGLE(c) goes directly to HELD with the same HELD-entry actions.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt+1.
    - When cnt reaches DEBOUNCE_SCANS -> HELD: key_code<=cand, key_valid=1 for exactly 1 cycle, key_held<=1.
    - Any other result (NONE, MULTI, different code) -> IDLE, cnt=0.
  - HELD:
    - NONE -> RELEASE, cnt=1.
    - SINGLE (any code) or MULTI -> stay; key_code unchanged; no new strobe.
  - RELEASE:
    - NONE -> cnt+1.
    - When cnt reaches DEBOUNCE_SCANS -> IDLE, key_held<=0.
    - Any press -> HELD, no strobe.
- Latency:
  - key_valid asserts at the scan-end tick of the DEBOUNCE_SCANS-th consecutive matching scan.
  - Worst case from a stable press: (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 2 cycles.
- Strobe count: one key_valid per accepted press, regardless of hold duration.
- Simultaneous events: rst dominates all; tick and scan-end classification occur in the same cycle, using the col 3 sample.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3; 1 scan = 16 cycles; the keypad model pulls row r low when col_n[c]=0 and key (r,c) is pressed):
1. Reset then idle -> col_n=1110 after reset, then 1101, 1011, 0111, 1110, stepping every 4 cycles; key_valid, key_held and multi_key stay 0 for 10 scans.
2. Hold key (row2,col1) for 10 scans -> exactly one key_valid pulse with key_code=9 within 64 cycles + 2; key_held=1 until release; no further strobes.
3. Press/release key 9 alternating every scan for 8 scans -> key_valid never asserts; key_held stays 0.
4. After case 2, release -> key_held falls after 3 consecutive NONE scans; re-press key 0 -> second strobe with key_code=0.
5. Hold keys 0 and 5 together -> multi_key=1 at each scan end; no key_valid; releasing key 5 leaves key 0 alone -> key_valid with key_code=0 after 3 scans and multi_key=0.
6. Assert rst after 2 matching scans in DEBOUNCE -> all outputs at reset values, col_n=1110, no strobe; after deassert, a held key is accepted only after 3 fresh scans.
